// File: rtl/c1_pkg.sv
// C1 bus shared definitions: opcodes, arbiter FSM states, opcode class helpers.
package c1_pkg;

    localparam logic [2:0] C1_NOP      = 3'd0;
    localparam logic [2:0] C1_READ8    = 3'd1;
    localparam logic [2:0] C1_READ16   = 3'd2;
    localparam logic [2:0] C1_READ32   = 3'd3;
    localparam logic [2:0] C1_INV_LINE = 3'd4;
    localparam logic [2:0] C1_WRITE8   = 3'd5;
    localparam logic [2:0] C1_WRITE16  = 3'd6;
    localparam logic [2:0] C1_WRITE32  = 3'd7;
    // The cache answers on the command line with the same code as WRITE32.
    localparam logic [2:0] C1_RESPONSE = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A1,
        ST_A2,
        ST_TURN,
        ST_WAIT,
        ST_R2,
        ST_DONE
    } c1_state_e;

    function automatic logic is_write(input logic [2:0] cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
    endfunction

    function automatic logic is_read(input logic [2:0] cmd);
        return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping around.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/c1_bus_arbiter.sv
// Shares the C1 CPU-to-cache bus between NUM_REQ requesters and sequences
// each transaction: address phases, turnaround, wait for response, data return.
module c1_bus_arbiter
    import c1_pkg::*;
#(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int BUS_SIZE          = 16,
    parameter int NUM_REQ           = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQ-1:0]                           req_valid,
    input  logic [3*NUM_REQ-1:0]                         req_cmd,
    input  logic [MEM_ADDR_SIZE*NUM_REQ-1:0]             req_addr,
    input  logic [2*BUS_SIZE*NUM_REQ-1:0]                req_wdata,
    output logic [NUM_REQ-1:0]                           req_done,
    output logic [2*BUS_SIZE-1:0]                        rdata,
    output logic [2:0]                                   c1_cmd_out,
    output logic                                         c1_cmd_oe,
    input  logic [2:0]                                   c1_cmd_in,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0]   c1_addr,
    output logic [BUS_SIZE-1:0]                          c1_data_out,
    output logic                                         c1_data_oe,
    input  logic [BUS_SIZE-1:0]                          c1_data_in
);

    localparam int CA = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int DW = 2 * BUS_SIZE;
    localparam int IW = $clog2(NUM_REQ);

    c1_state_e                state;
    logic [IW-1:0]            rr_ptr;
    logic [IW-1:0]            owner;
    logic [2:0]               lat_cmd;
    logic [MEM_ADDR_SIZE-1:0] lat_addr;
    logic [DW-1:0]            lat_wdata;

    logic [NUM_REQ-1:0]       win_grant;
    logic [IW-1:0]            win_idx;
    logic                     win_any;
    logic [2:0]               win_cmd;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign win_cmd = req_cmd[int'(win_idx)*3 +: 3];

    // Transaction sequencer: latch the winner in IDLE, walk the bus phases,
    // capture read data, advance the round-robin pointer on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            lat_cmd   <= C1_NOP;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (win_any) begin
                    owner     <= win_idx;
                    lat_cmd   <= win_cmd;
                    lat_addr  <= req_addr[int'(win_idx)*MEM_ADDR_SIZE +: MEM_ADDR_SIZE];
                    lat_wdata <= req_wdata[int'(win_idx)*DW +: DW];
                    // A NOP has nothing to put on the bus; just acknowledge it.
                    state     <= (win_cmd == C1_NOP) ? ST_DONE : ST_A1;
                end
                ST_A1:   state <= ST_A2;
                ST_A2:   state <= ST_TURN;
                ST_TURN: state <= ST_WAIT;
                ST_WAIT: if (c1_cmd_in == C1_RESPONSE) begin
                    if (is_read(lat_cmd)) begin
                        case (lat_cmd)
                            C1_READ8:  rdata <= DW'(c1_data_in[7:0]);
                            C1_READ16: rdata <= DW'(c1_data_in);
                            default:   rdata[BUS_SIZE-1:0] <= c1_data_in;
                        endcase
                    end
                    state <= (lat_cmd == C1_READ32) ? ST_R2 : ST_DONE;
                end
                ST_R2: begin
                    rdata[DW-1:BUS_SIZE] <= c1_data_in;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    rr_ptr <= (int'(owner) == NUM_REQ-1) ? '0 : owner + IW'(1);
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus drive and completion pulse decoded from the current phase.
    always_comb begin
        req_done    = '0;
        c1_cmd_out  = C1_NOP;
        c1_cmd_oe   = 1'b1;
        c1_addr     = '0;
        c1_data_out = '0;
        c1_data_oe  = 1'b0;
        case (state)
            ST_A1: begin
                c1_cmd_out = lat_cmd;
                c1_addr    = lat_addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
                if (is_write(lat_cmd)) begin
                    c1_data_out = lat_wdata[BUS_SIZE-1:0];
                    c1_data_oe  = 1'b1;
                end
            end
            ST_A2: begin
                c1_cmd_out = lat_cmd;
                c1_addr    = CA'(lat_addr[CACHE_OFFSET_SIZE-1:0]);
                if (is_write(lat_cmd)) begin
                    c1_data_out = lat_wdata[DW-1:BUS_SIZE];
                    c1_data_oe  = 1'b1;
                end
            end
            // Release both lines so the cache can drive them.
            ST_TURN, ST_WAIT, ST_R2: c1_cmd_oe = 1'b0;
            ST_DONE: req_done[owner] = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_c1_bus_arbiter.sv
// Directed bench for c1_bus_arbiter: walks each transaction cycle by cycle.
module tb_c1_bus_arbiter;
    import c1_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [5:0]  req_cmd;
    logic [37:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_done;
    logic [31:0] rdata;
    logic [2:0]  c1_cmd_out;
    logic        c1_cmd_oe;
    logic [2:0]  c1_cmd_in;
    logic [14:0] c1_addr;
    logic [15:0] c1_data_out;
    logic        c1_data_oe;
    logic [15:0] c1_data_in;

    int checks = 0;
    int failures = 0;

    c1_bus_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
        .rdata(rdata), .c1_cmd_out(c1_cmd_out), .c1_cmd_oe(c1_cmd_oe),
        .c1_cmd_in(c1_cmd_in), .c1_addr(c1_addr), .c1_data_out(c1_data_out),
        .c1_data_oe(c1_data_oe), .c1_data_in(c1_data_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_cmd = '0; req_addr = '0; req_wdata = '0;
        c1_cmd_in = 3'd0; c1_data_in = '0;
        tick(); tick();
        reset = 1'b0;

        // 1) idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_cmd_oe", 32'(c1_cmd_oe), 32'd1);
            chk("idle_cmd_out", 32'(c1_cmd_out), 32'd0);
            chk("idle_data_oe", 32'(c1_data_oe), 32'd0);
            chk("idle_done", 32'(req_done), 32'd0);
        end
        chk("idle_rdata", rdata, 32'd0);

        // 2) port0 READ32 at 0x00123
        req_cmd[2:0] = C1_READ32; req_addr[18:0] = 19'h00123; req_valid = 2'b01;
        tick(); // A1
        chk("r32_a1_addr", 32'(c1_addr), 32'h0012);
        chk("r32_a1_cmd", 32'(c1_cmd_out), 32'd3);
        chk("r32_a1_oe", 32'(c1_cmd_oe), 32'd1);
        chk("r32_a1_doe", 32'(c1_data_oe), 32'd0);
        tick(); // A2
        chk("r32_a2_addr", 32'(c1_addr), 32'h3);
        chk("r32_a2_cmd", 32'(c1_cmd_out), 32'd3);
        tick(); // TURN
        chk("r32_turn_oe", 32'(c1_cmd_oe), 32'd0);
        chk("r32_turn_doe", 32'(c1_data_oe), 32'd0);
        tick(); // WAIT
        chk("r32_wait_oe", 32'(c1_cmd_oe), 32'd0);
        tick(); // WAIT, cache now responds
        c1_cmd_in = C1_RESPONSE; c1_data_in = 16'hBEEF;
        chk("r32_resp_oe", 32'(c1_cmd_oe), 32'd0);
        chk("r32_resp_done", 32'(req_done), 32'd0);
        tick(); // R2
        chk("r32_r2_lo", rdata, 32'h0000BEEF);
        chk("r32_r2_done", 32'(req_done), 32'd0);
        c1_cmd_in = 3'd0; c1_data_in = 16'hCAFE;
        tick(); // DONE
        chk("r32_done", 32'(req_done), 32'b01);
        chk("r32_rdata", rdata, 32'hCAFEBEEF);
        chk("r32_done_oe", 32'(c1_cmd_oe), 32'd1);
        req_valid = 2'b00;
        tick(); // IDLE
        chk("r32_idle_done", 32'(req_done), 32'd0);

        // 3) both ports valid from reset; port0 keeps re-requesting
        reset = 1'b1; req_valid = 2'b11;
        req_cmd = {C1_READ16, C1_READ16};
        req_addr = {19'h00020, 19'h00010};
        tick(); tick();
        reset = 1'b0;
        tick(); // A1, port0
        chk("rr_first_addr", 32'(c1_addr), 32'h1);
        tick(); tick(); tick(); // A2, TURN, WAIT
        c1_cmd_in = C1_RESPONSE; c1_data_in = 16'h1111;
        tick(); // DONE
        c1_cmd_in = 3'd0;
        chk("rr_first_done", 32'(req_done), 32'b01);
        chk("rr_first_rdata", rdata, 32'h00001111);
        tick(); // IDLE, both still valid
        tick(); // A1, port1 must win
        chk("rr_second_addr", 32'(c1_addr), 32'h2);
        tick(); tick(); tick();
        c1_cmd_in = C1_RESPONSE; c1_data_in = 16'h5A5A;
        tick(); // DONE
        c1_cmd_in = 3'd0;
        chk("rr_second_done", 32'(req_done), 32'b10);
        chk("rr_second_rdata", rdata, 32'h00005A5A);
        req_valid = 2'b00;
        tick();

        // 4) port1 WRITE16 at 0x7FFF0
        req_cmd[5:3] = C1_WRITE16; req_addr[37:19] = 19'h7FFF0;
        req_wdata[63:32] = 32'h1234ABCD; req_valid = 2'b10;
        tick(); // A1
        chk("w16_a1_data", 32'(c1_data_out), 32'hABCD);
        chk("w16_a1_doe", 32'(c1_data_oe), 32'd1);
        chk("w16_a1_addr", 32'(c1_addr), 32'h7FFF);
        chk("w16_a1_cmd", 32'(c1_cmd_out), 32'd6);
        tick(); // A2
        chk("w16_a2_data", 32'(c1_data_out), 32'h1234);
        chk("w16_a2_doe", 32'(c1_data_oe), 32'd1);
        chk("w16_a2_addr", 32'(c1_addr), 32'h0);
        tick(); // TURN
        chk("w16_turn_doe", 32'(c1_data_oe), 32'd0);
        chk("w16_turn_oe", 32'(c1_cmd_oe), 32'd0);
        tick(); // WAIT
        c1_cmd_in = C1_RESPONSE; c1_data_in = 16'hFFFF;
        chk("w16_resp_doe", 32'(c1_data_oe), 32'd0);
        tick(); // DONE
        c1_cmd_in = 3'd0;
        chk("w16_done", 32'(req_done), 32'b10);
        chk("w16_rdata_kept", rdata, 32'h00005A5A);
        req_valid = 2'b00;
        tick();

        // 5) reset during WAIT aborts with no done
        req_cmd[5:3] = C1_READ8; req_valid = 2'b10;
        tick(); tick(); tick(); tick(); // A1, A2, TURN, WAIT
        chk("rst_in_wait_oe", 32'(c1_cmd_oe), 32'd0);
        reset = 1'b1; req_valid = 2'b00;
        tick();
        chk("rst_oe", 32'(c1_cmd_oe), 32'd1);
        chk("rst_cmd", 32'(c1_cmd_out), 32'd0);
        chk("rst_done", 32'(req_done), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_after_done", 32'(req_done), 32'd0);

        // 6) port0 READ8 at 0x00005 against a waiting port1
        req_cmd = {C1_READ16, C1_READ8};
        req_addr = {19'h00020, 19'h00005}; req_valid = 2'b11;
        tick(); // A1
        chk("r8_a1_addr", 32'(c1_addr), 32'h0);
        chk("r8_a1_cmd", 32'(c1_cmd_out), 32'd1);
        tick(); // A2
        chk("r8_a2_addr", 32'(c1_addr), 32'h5);
        tick(); tick(); // TURN, WAIT
        c1_cmd_in = C1_RESPONSE; c1_data_in = 16'h12A5;
        chk("r8_resp_oe", 32'(c1_cmd_oe), 32'd0);
        chk("r8_resp_doe", 32'(c1_data_oe), 32'd0);
        tick(); // DONE
        c1_cmd_in = 3'd0;
        chk("r8_done", 32'(req_done), 32'b01);
        chk("r8_rdata", rdata, 32'h000000A5);
        req_valid = 2'b00;
        tick();

        // 7) NOP request completes without bus activity
        req_cmd[2:0] = C1_NOP; req_valid = 2'b01;
        tick(); // DONE directly
        chk("nop_done", 32'(req_done), 32'b01);
        chk("nop_oe", 32'(c1_cmd_oe), 32'd1);
        chk("nop_cmd", 32'(c1_cmd_out), 32'd0);
        req_valid = 2'b00;
        tick();
        chk("nop_idle_done", 32'(req_done), 32'd0);
        chk("nop_rdata_kept", rdata, 32'h000000A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
